// File: rtl/pc_trace_buffer.sv
// pc_trace_buffer: non-intrusive execution trace. One (pc, inst) record is
// captured per newly fetched instruction into a first-word-fall-through FIFO,
// which a consumer drains over valid/ready. Records that arrive while the
// FIFO is full are dropped and counted. The CPU is never stalled.
module pc_trace_buffer #(
  parameter int DEPTH  = 16,
  parameter int AW     = 4,
  parameter int DROP_W = 8
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic [31:0]       pc,
  input  logic [31:0]       inst,
  input  logic              capture_en,
  input  logic              clear,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_pc,
  output logic [31:0]       out_inst,
  output logic [AW:0]       count,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_cnt
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } rec_t;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  rec_t        mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [31:0] last_pc;
  logic        last_pc_vld;
  logic        new_rec, full, empty, pop, push, drop;
  rec_t        head;

  // Occupancy is the pointer difference; the extra bit separates full from empty.
  assign count = wr_ptr - rd_ptr;
  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);

  // A record is new when tracing is armed and pc moved (or tracker just re-armed).
  assign new_rec = capture_en & (~last_pc_vld | (pc != last_pc));

  // Clear wins over everything; a full FIFO still accepts a push if it pops too.
  assign pop  = out_valid & out_ready & ~clear;
  assign push = new_rec & (~full | pop) & ~clear;
  assign drop = new_rec & full & ~pop & ~clear;

  // FWFT head: combinational from the head entry, zero while empty.
  assign head      = mem[rd_ptr[AW-1:0]];
  assign out_valid = ~empty;
  assign out_pc    = empty ? 32'h0 : head.pc;
  assign out_inst  = empty ? 32'h0 : head.inst;

  // Storage array; no reset needed since entries are only read when valid.
  always_ff @(posedge clk_in) begin
    if (push) mem[wr_ptr[AW-1:0]] <= '{pc: pc, inst: inst};
  end

  // Pointers, overflow flag and saturating drop counter.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

  // Last-pc tracker; disarming forgets it so re-arming always records.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      last_pc     <= '0;
      last_pc_vld <= 1'b0;
    end else if (clear) begin
      last_pc     <= '0;
      last_pc_vld <= 1'b0;
    end else if (capture_en) begin
      last_pc     <= pc;
      last_pc_vld <= 1'b1;
    end else begin
      last_pc_vld <= 1'b0;
    end
  end

endmodule
